// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Two-requester round-robin front end for the shared serial shift-add
// multiplier. A granted operand pair is fed over the multiplier's single
// operand bus (multiplier, then multiplicand). After the multiplier's fixed
// latency, the product is captured and returned tagged with the requester id.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-low reset
//   req0/a0/b0, ack0    requester 0: request held with operands until ack0 pulse
//   req1/a1/b1, ack1    requester 1: same handshake
//   mult_rst_n          multiplier reset/start, low while idle
//   mult_operand        serial operand bus into the multiplier
//   mult_product        product from the multiplier
//   busy                high whenever an operation is in progress
//   result/result_id    last captured product and its owner, held between pulses
//   result_valid        one-cycle pulse when result/result_id are updated
//
// Every output is a register. Each is loaded with the value that belongs to the
// state being entered, so outputs line up with the state they describe.
// MULT_LAT must be >= 1.

module mult_share_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MULT_LAT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_W-1:0]     a0,
  input  logic [DATA_W-1:0]     b0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [DATA_W-1:0]     a1,
  input  logic [DATA_W-1:0]     b1,
  output logic                  ack1,
  output logic                  mult_rst_n,
  output logic [DATA_W-1:0]     mult_operand,
  input  logic [2*DATA_W-1:0]   mult_product,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_valid,
  output logic                  result_id
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_A = 2'd1;
  localparam logic [1:0] ST_LOAD_B = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam int              CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

  logic [1:0]        state_r;
  logic [DATA_W-1:0] a_lat_r;
  logic [DATA_W-1:0] b_lat_r;
  logic              id_r;
  logic              last_gnt_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              grant_s;
  logic              gnt_id_s;
  logic [DATA_W-1:0] gnt_a_s;
  logic [DATA_W-1:0] gnt_b_s;

  // Round-robin choice among the requests currently presented; a tie goes to
  // the requester that was not granted last.
  always_comb begin
    grant_s = req0 | req1;
    if (req0 && req1) begin
      gnt_id_s = ~last_gnt_r;
    end else if (req1) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    if (gnt_id_s) begin
      gnt_a_s = a1;
      gnt_b_s = b1;
    end else begin
      gnt_a_s = a0;
      gnt_b_s = b0;
    end
  end

  // Sequencer state, latched operands and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      a_lat_r      <= {DATA_W{1'b0}};
      b_lat_r      <= {DATA_W{1'b0}};
      id_r         <= 1'b0;
      last_gnt_r   <= 1'b1;   // requester 0 wins the first tie
      cnt_r        <= {CNT_W{1'b0}};
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      mult_rst_n   <= 1'b0;
      mult_operand <= {DATA_W{1'b0}};
      busy         <= 1'b0;
      result       <= {(2*DATA_W){1'b0}};
      result_valid <= 1'b0;
      result_id    <= 1'b0;
    end else begin
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      result_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            a_lat_r      <= gnt_a_s;
            b_lat_r      <= gnt_b_s;
            id_r         <= gnt_id_s;
            last_gnt_r   <= gnt_id_s;
            state_r      <= ST_LOAD_A;
            ack0         <= ~gnt_id_s;
            ack1         <= gnt_id_s;
            mult_rst_n   <= 1'b1;
            mult_operand <= gnt_a_s;
            busy         <= 1'b1;
          end else begin
            mult_rst_n   <= 1'b0;
            mult_operand <= {DATA_W{1'b0}};
            busy         <= 1'b0;
          end
        end
        ST_LOAD_A: begin
          state_r      <= ST_LOAD_B;
          mult_rst_n   <= 1'b1;
          mult_operand <= b_lat_r;
          busy         <= 1'b1;
        end
        ST_LOAD_B: begin
          state_r      <= ST_WAIT;
          cnt_r        <= {CNT_W{1'b0}};
          mult_rst_n   <= 1'b1;
          mult_operand <= {DATA_W{1'b0}};
          busy         <= 1'b1;
        end
        ST_WAIT: begin
          cnt_r        <= cnt_r + CNT_W'(1'b1);
          mult_operand <= {DATA_W{1'b0}};
          if (cnt_r == CNT_LAST) begin
            // Product is valid during this last wait cycle; capture it and
            // drop the multiplier back into reset for the idle cycle.
            state_r      <= ST_IDLE;
            result       <= mult_product;
            result_id    <= id_r;
            result_valid <= 1'b1;
            mult_rst_n   <= 1'b0;
            busy         <= 1'b0;
          end else begin
            mult_rst_n   <= 1'b1;
            busy         <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          mult_rst_n   <= 1'b0;
          mult_operand <= {DATA_W{1'b0}};
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int DW  = 8;
  localparam int LAT = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            req0, req1;
  logic [DW-1:0]   a0, b0, a1, b1;
  logic            ack0, ack1;
  logic            mult_rst_n;
  logic [DW-1:0]   mult_operand;
  logic [2*DW-1:0] mult_product = '0;
  logic            busy;
  logic [2*DW-1:0] result;
  logic            result_valid;
  logic            result_id;

  always #5 clock = ~clock;

  mult_share_arbiter #(.DATA_W(DW), .MULT_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .mult_rst_n(mult_rst_n), .mult_operand(mult_operand),
    .mult_product(mult_product), .busy(busy),
    .result(result), .result_valid(result_valid), .result_id(result_id)
  );

  // Behavioural serial multiplier: takes multiplier then multiplicand, shows
  // junk until the product becomes valid in the last compute cycle.
  logic [DW-1:0] ma = '0, mb = '0;
  int mph = 0, mk = 0;
  always @(posedge clock) begin
    if (!mult_rst_n) begin
      mph <= 0;
      mult_product <= 16'($urandom);
    end else begin
      case (mph)
        0: begin ma <= mult_operand; mph <= 1; mult_product <= 16'($urandom); end
        1: begin mb <= mult_operand; mk <= 0; mph <= 2; mult_product <= 16'($urandom); end
        2: begin
          if (mk == LAT - 2) begin
            mult_product <= 16'(ma) * 16'(mb);
            mph <= 3;
          end else begin
            mk <= mk + 1;
            mult_product <= 16'($urandom);
          end
        end
        default: mph <= 3;
      endcase
    end
  end

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; int gap; } op_t;
  typedef struct { logic id; logic [2*DW-1:0] prod; int due; } exp_t;

  op_t  opq [2][$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state (edge-indexed): an op granted at edge g acks in
  // cycle g, loads b in g+1, returns its result in g+2+LAT, and the next
  // grant may happen at edge g+3+LAT.
  int            m_free   = 0;
  logic          m_last   = 1'b1;
  logic          m_active = 1'b0;
  int            m_g      = 0;
  logic          m_id     = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic          last_rst = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, expv);
    end
  endtask

  // Requester drivers: present queued ops, hold until ack, scramble operands afterwards.
  logic          req_d [2];
  logic [DW-1:0] a_d [2];
  logic [DW-1:0] b_d [2];
  int            dst [2];
  assign req0 = req_d[0];
  assign req1 = req_d[1];
  assign a0 = a_d[0];
  assign b0 = b_d[0];
  assign a1 = a_d[1];
  assign b1 = b_d[1];

  initial begin
    logic ackv;
    for (int i = 0; i < 2; i++) begin
      req_d[i] = 1'b0; a_d[i] = '0; b_d[i] = '0; dst[i] = 0;
    end
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < 2; i++) begin
        ackv = (i == 0) ? ack0 : ack1;
        if (dst[i] == 1) begin
          if (ackv) begin
            void'(opq[i].pop_front());
            dst[i] = 2;
          end
        end else begin
          if (dst[i] == 2) begin
            a_d[i] = 8'($urandom);
            b_d[i] = 8'($urandom);
            dst[i] = 0;
          end
          if (opq[i].size() > 0 && opq[i][0].gap > 0) begin
            opq[i][0].gap = opq[i][0].gap - 1;
            req_d[i] = 1'b0;
          end else if (opq[i].size() > 0) begin
            req_d[i] = 1'b1;
            a_d[i] = opq[i][0].a;
            b_d[i] = opq[i][0].b;
            dst[i] = 1;
          end else begin
            req_d[i] = 1'b0;
          end
        end
      end
    end
  end

  // Reference model: decides grants from the sampled requests and pushes expectations.
  initial begin
    logic w;
    exp_t e;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      if (!reset) begin
        exp_q.delete();
        m_active = 1'b0;
        m_last   = 1'b1;
        m_free   = cyc + 1;
        last_rst = 1'b1;
      end else begin
        last_rst = 1'b0;
        if (cyc >= m_free && (req0 || req1)) begin
          w = (req0 && req1) ? ~m_last : req1;
          m_last   = w;
          m_active = 1'b1;
          m_g      = cyc;
          m_id     = w;
          m_a      = w ? a1 : a0;
          m_b      = w ? b1 : b0;
          m_free   = cyc + 3 + LAT;
          e.id   = w;
          e.prod = 16'(m_a) * 16'(m_b);
          e.due  = cyc + 2 + LAT;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: checks per-cycle control outputs and scoreboards results.
  initial begin
    logic [2*DW-1:0] hold_res;
    logic            hold_id;
    logic            in_op;
    logic [DW-1:0]   exp_opnd;
    exp_t            e;
    hold_res = '0;
    hold_id  = 1'b0;
    forever begin
      @(negedge clock);
      if (cyc >= 1) begin
        in_op = m_active && cyc >= m_g && cyc <= m_g + 2 + LAT;
        exp_opnd = (in_op && cyc == m_g) ? m_a :
                   (in_op && cyc == m_g + 1) ? m_b : 8'd0;
        chk("ack0", ack0, in_op && cyc == m_g && !m_id);
        chk("ack1", ack1, in_op && cyc == m_g && m_id);
        chk("busy", busy, in_op && cyc <= m_g + 1 + LAT);
        chk("mult_rst_n", mult_rst_n, in_op && cyc <= m_g + 1 + LAT);
        chk("mult_operand", mult_operand, exp_opnd);
        if (last_rst) begin
          hold_res = '0;
          hold_id  = 1'b0;
        end
        if (result_valid) begin
          if (exp_q.size() == 0) begin
            chk("result_valid_spurious", result_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("result_cycle", cyc, e.due);
            chk("result", result, e.prod);
            chk("result_id", result_id, e.id);
            hold_res = e.prod;
            hold_id  = e.id;
          end
        end else begin
          if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("result_valid_missing", result_valid, 1);
            void'(exp_q.pop_front());
          end
          chk("result_hold", result, hold_res);
          chk("result_id_hold", result_id, hold_id);
        end
      end
    end
  end

  task automatic push(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
    op_t o;
    o.a = a; o.b = b; o.gap = gap;
    opq[who].push_back(o);
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    for (int k = 0; k < limit && !done; k++) begin
      @(posedge clock); #1;
      if (opq[0].size() == 0 && opq[1].size() == 0 && exp_q.size() == 0 && cyc >= m_free)
        done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout cycle %0d: got pending work, want idle", cyc);
    end
  endtask

  function automatic logic [DW-1:0] rop();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bit found;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Single ops from each client.
    push(0, 8'd9, 8'd5, 0);
    drain(200);
    push(1, 8'd200, 8'd220, 0);
    drain(200);

    // Both held from reset release; two rounds to see alternation.
    reset = 1'b0;
    push(0, 8'd3, 8'd4, 0); push(1, 8'd6, 8'd7, 0);
    push(0, 8'd3, 8'd4, 0); push(1, 8'd6, 8'd7, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drain(300);

    // Back-to-back on one client, including extreme operands.
    push(0, 8'd255, 8'd255, 0);
    push(0, 8'd0, 8'd123, 0);
    drain(200);

    // Reset during WAIT (counter==3), then a tie to check tie-break reset.
    push(0, 8'd50, 8'd60, 0);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clock); #1;
      if (m_active && cyc == m_g + 5) found = 1'b1;
    end
    chk("wait_for_mid_op", found, 1);
    reset = 1'b0;
    push(0, 8'd5, 8'd6, 0);
    push(1, 8'd10, 8'd10, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drain(300);

    // Randomized traffic from both clients with random gaps.
    for (int n = 0; n < 25; n++) begin
      push(0, rop(), rop(), $urandom_range(0, 12));
      push(1, rop(), rop(), $urandom_range(0, 12));
    end
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
